// File: rtl/alu_serie_pkg.sv
// Shared definitions for the bit-serial ALU: logic select codes and FSM states.
package alu_serie_pkg;

    localparam logic [1:0] S_AND  = 2'b00;
    localparam logic [1:0] S_OR   = 2'b01;
    localparam logic [1:0] S_XOR  = 2'b10;
    localparam logic [1:0] S_NOTA = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

endpackage

// File: rtl/alu_serie_cal.sv
// One-bit arithmetic/logic cell: full adder when l=0, bitwise op selected by s when l=1.
module cal
    import alu_serie_pkg::*;
(
    output logic       out,
    output logic       c_out,
    input  logic       a,
    input  logic       b,
    input  logic       l,
    input  logic       c_in,
    input  logic [1:0] s
);

    always_comb begin
        out   = a ^ b ^ c_in;
        c_out = (a & b) | (c_in & (a ^ b));
        if (l) begin
            c_out = 1'b0;
            unique case (s)
                S_AND:   out = a & b;
                S_OR:    out = a | b;
                S_XOR:   out = a ^ b;
                default: out = ~a;
            endcase
        end
    end

endmodule

// File: rtl/alu_serie.sv
// Bit-serial N-bit ALU: drives one cal cell LSB first over N cycles with a start/done handshake.
module alu_serie
    import alu_serie_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         l,
    input  logic [1:0]   s,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         c_out,
    output logic         zero
);

    localparam int unsigned CNT_W = $clog2(N);

    state_t           r_state;
    state_t           w_next;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_res;
    logic             r_l;
    logic [1:0]       r_s;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic             w_out;
    logic             w_cout;

    cal u_cal (
        .out   (w_out),
        .c_out (w_cout),
        .a     (r_a[0]),
        .b     (r_b[0]),
        .l     (r_l),
        .c_in  (r_carry),
        .s     (r_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (r_cnt == CNT_W'(N - 1)) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, serial shift and carry feedback.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_l     <= 1'b0;
            r_s     <= 2'b00;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_l     <= l;
                        r_s     <= s;
                        r_carry <= l ? 1'b0 : cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_res   <= {w_out, r_res[N-1:1]};
                    r_a     <= {1'b0, r_a[N-1:1]};
                    r_b     <= {1'b0, r_b[N-1:1]};
                    r_carry <= r_l ? 1'b0 : w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                FIN: begin
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // zero reports only on a completed result, so it reads 0 straight out of reset.
    assign busy   = (r_state == RUN);
    assign done   = (r_state == FIN);
    assign result = r_res;
    assign c_out  = r_carry;
    assign zero   = (r_valid | done) & ~(|r_res);

endmodule

// File: tb/tb_alu_serie.sv
// Self-checking bench for alu_serie (N=4): vector table, scoreboard on done, handshake corners.
module tb_alu_serie;

    localparam int unsigned N = 4;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         l;
        logic [1:0]   s;
        logic         cin;
        logic [N-1:0] er;
        logic         ec;
        logic         ez;
    } vec_t;

    typedef struct packed {
        logic [N-1:0] res;
        logic         c;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         l;
    logic [1:0]   s;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         c_out;
    logic         zero;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    vec_t vecs[10];

    alu_serie #(.N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .l      (l),
        .s      (s),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .c_out  (c_out),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                   input logic ml, input logic [1:0] ms, input logic mc);
        exp_t       e;
        logic [N:0] sum;
        if (!ml) begin
            sum   = {1'b0, ma} + {1'b0, mb} + (N+1)'(mc);
            e.res = sum[N-1:0];
            e.c   = sum[N];
        end else begin
            e.c = 1'b0;
            case (ms)
                2'b00:   e.res = ma & mb;
                2'b01:   e.res = ma | mb;
                2'b10:   e.res = ma ^ mb;
                default: e.res = ~ma;
            endcase
        end
        e.z = (e.res == '0);
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("c_out",  32'(c_out),  32'(e.c));
                check("zero",   32'(zero),   32'(e.z));
            end
        end
    end

    task automatic run_op(input vec_t v, input logic mid_change);
        int lat;
        @(negedge clk);
        a = v.a; b = v.b; l = v.l; s = v.s; cin = v.cin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sb.push_back({v.er, v.ec, v.ez});
        check("busy_after_start", 32'(busy), 32'd1);
        if (mid_change) begin
            a = ~a; b = ~b; l = ~l; cin = ~cin; s = ~s;
        end
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (!done) check("busy_in_run", 32'(busy), 32'd1);
        end
        check("latency", 32'(lat), 32'(N));
        check("busy_in_fin", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int   t_done[3];
        int   nd;
        int   cyc;
        vec_t v;
        exp_t e;

        //          a        b        l     s      cin   er       ec    ez
        vecs[0] = {4'b0101, 4'b0011, 1'b0, 2'b00, 1'b0, 4'b1000, 1'b0, 1'b0};
        vecs[1] = {4'b1111, 4'b0001, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b1, 1'b1};
        vecs[2] = {4'b0101, 4'b1100, 1'b0, 2'b00, 1'b1, 4'b0010, 1'b1, 1'b0};
        vecs[3] = {4'b1100, 4'b1010, 1'b1, 2'b00, 1'b0, 4'b1000, 1'b0, 1'b0};
        vecs[4] = {4'b1100, 4'b1010, 1'b1, 2'b01, 1'b1, 4'b1110, 1'b0, 1'b0};
        vecs[5] = {4'b1100, 4'b1010, 1'b1, 2'b10, 1'b0, 4'b0110, 1'b0, 1'b0};
        vecs[6] = {4'b1010, 4'b0000, 1'b1, 2'b11, 1'b1, 4'b0101, 1'b0, 1'b0};
        vecs[7] = {4'b0011, 4'b1100, 1'b1, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b1};
        vecs[8] = {4'b0000, 4'b0000, 1'b0, 2'b00, 1'b1, 4'b0001, 1'b0, 1'b0};
        vecs[9] = {4'b0111, 4'b0001, 1'b0, 2'b11, 1'b0, 4'b1000, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; a = '0; b = '0; l = 1'b0; s = 2'b00; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_c_out",  32'(c_out),  32'd0);
        check("rst_zero",   32'(zero),   32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_op(vecs[i], 1'b0);

        // Result, carry and zero stay held while idle.
        repeat (4) @(posedge clk);
        #1;
        check("held_result", 32'(result), 32'(vecs[9].er));
        check("held_c_out",  32'(c_out),  32'(vecs[9].ec));
        check("held_zero",   32'(zero),   32'(vecs[9].ez));

        // Inputs toggled after capture must not affect the running operation.
        run_op(vecs[0], 1'b1);
        run_op(vecs[2], 1'b1);

        // Random operations against the model.
        for (int i = 0; i < 8; i++) begin
            v.a = N'($urandom_range(0, (1 << N) - 1));
            v.b = N'($urandom_range(0, (1 << N) - 1));
            v.l = 1'($urandom_range(0, 1));
            v.s = 2'($urandom_range(0, 3));
            v.cin = 1'($urandom_range(0, 1));
            e = model(v.a, v.b, v.l, v.s, v.cin);
            v.er = e.res; v.ec = e.c; v.ez = e.z;
            run_op(v, 1'b0);
        end

        // start held high: one operation per N+2 cycles.
        @(negedge clk);
        a = 4'b0110; b = 4'b0011; l = 1'b0; s = 2'b00; cin = 1'b0; start = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back({4'b1001, 1'b0, 1'b0});
        nd = 0; cyc = 0;
        while (nd < 3 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                t_done[nd] = cyc;
                nd++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("held_start_pulses", 32'(nd), 32'd3);
        check("held_start_period1", 32'(t_done[1] - t_done[0]), 32'(N + 2));
        check("held_start_period2", 32'(t_done[2] - t_done[1]), 32'(N + 2));
        repeat (2) @(posedge clk);

        // Reset during RUN aborts with no done pulse.
        @(negedge clk);
        a = 4'b0101; b = 4'b0011; l = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy",   32'(busy),   32'd0);
        check("abort_done",   32'(done),   32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_c_out",  32'(c_out),  32'd0);
        check("abort_zero",   32'(zero),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (N + 4) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 32'd0);
        end
        run_op(vecs[1], 1'b0);
        run_op(vecs[5], 1'b0);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
